voice_allocator: RTL

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/synth_pkg.sv | 31 +++
 rtl/voice_slot.sv | 36 +++
 rtl/voice_allocator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the voice allocator: command layout, special note codes
// and the allocator state encoding.
package synth_pkg;

    localparam int unsigned CMD_W          = 16;
    localparam int unsigned NOTE_W         = 7;
    localparam int unsigned VEL_W          = 8;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned NUM_VOICES_DEF = 10;

    localparam int unsigned CMD_START_BIT = 15;
    localparam int unsigned CMD_NOTE_HI   = 14;
    localparam int unsigned CMD_NOTE_LO   = 8;

    localparam logic [NOTE_W-1:0] STOP_ALL_NOTE = 7'h7F;

    typedef struct packed {
        logic              start;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  vel;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_INIT_CLR = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_WRITE    = 3'd3,
        ST_CLR_ALL  = 3'd4
    } state_e;

endpackage

// File: rtl/voice_slot.sv
// One voice table entry: note and age, with clear > set > age-increment priority.
module voice_slot
    import synth_pkg::*;
#(
    parameter int unsigned AGE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic [NOTE_W-1:0] set_note,
    input  logic              clr,
    input  logic              age_inc,
    output logic [NOTE_W-1:0] note,
    output logic [AGE_W-1:0]  age,
    output logic              active
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note   <= '0;
            age    <= '0;
            active <= 1'b0;
        end else if (clr) begin
            note   <= '0;
            age    <= '0;
            active <= 1'b0;
        end else if (set) begin
            note   <= set_note;
            age    <= '0;
            active <= (set_note != '0);
        end else if (age_inc && active && (age != '1)) begin
            age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: accepts START/STOP commands, scans the slot table one entry per
// cycle and writes the chosen slot's configuration to the phase bank.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_cmd_valid,
    input  logic [CMD_W-1:0]      i_cmd_data,
    output logic                  o_cmd_ready,
    output logic                  o_voice_wr,
    output logic [IDX_W-1:0]      o_voice_idx,
    output logic [CMD_W-1:0]      o_voice_data,
    output logic [NUM_VOICES-1:0] o_active,
    output logic                  o_steal
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic              match_found_q, match_found_d;
    logic [IDX_W-1:0]  match_idx_q, match_idx_d;
    logic              free_found_q, free_found_d;
    logic [IDX_W-1:0]  free_idx_q, free_idx_d;
    logic [IDX_W-1:0]  old_idx_q, old_idx_d;
    logic [AGE_W-1:0]  old_age_q, old_age_d;

    logic              wr_d, steal_d;
    logic [IDX_W-1:0]  idx_d, wr_idx;
    logic [CMD_W-1:0]  data_d;

    logic [NOTE_W-1:0]     slot_note [NUM_VOICES];
    logic [AGE_W-1:0]      slot_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] slot_active, slot_set, slot_clr;
    logic                  age_inc;

    logic [NOTE_W-1:0] cur_note;
    logic [AGE_W-1:0]  cur_age;
    logic              cur_active;

    logic [NOTE_W-1:0] new_note;
    logic              new_start;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot #(.AGE_W(AGE_W)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .set      (slot_set[g]),
            .set_note (cmd_q.note),
            .clr      (slot_clr[g]),
            .age_inc  (age_inc),
            .note     (slot_note[g]),
            .age      (slot_age[g]),
            .active   (slot_active[g])
        );
    end

    assign o_active  = slot_active;
    assign new_note  = i_cmd_data[CMD_NOTE_HI:CMD_NOTE_LO];
    assign new_start = i_cmd_data[CMD_START_BIT];

    // Slot currently under the scan pointer (also the clear-sweep pointer)
    always_comb begin
        cur_note   = '0;
        cur_age    = '0;
        cur_active = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cur_note   = slot_note[i];
                cur_age    = slot_age[i];
                cur_active = slot_active[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        scan_idx_d    = scan_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        wr_d          = 1'b0;
        steal_d       = 1'b0;
        idx_d         = o_voice_idx;
        data_d        = o_voice_data;
        wr_idx        = '0;
        slot_set      = '0;
        slot_clr      = '0;
        age_inc       = 1'b0;

        unique case (state_q)
            ST_INIT_CLR, ST_CLR_ALL: begin
                wr_d   = 1'b1;
                idx_d  = scan_idx_q;
                data_d = '0;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (scan_idx_q == IDX_W'(i)) slot_clr[i] = 1'b1;
                end
                if (scan_idx_q == LAST_IDX) begin
                    scan_idx_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end

            ST_IDLE: begin
                if (i_cmd_valid) begin
                    cmd_d         = cmd_t'(i_cmd_data);
                    scan_idx_d    = '0;
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    free_found_d  = 1'b0;
                    free_idx_d    = '0;
                    old_idx_d     = '0;
                    old_age_d     = '0;
                    // START of note 0 / 7F is swallowed; STOP of 7F clears everything
                    if (new_start && (new_note == '0 || new_note == STOP_ALL_NOTE)) begin
                        state_d = ST_IDLE;
                    end else if (!new_start && new_note == STOP_ALL_NOTE) begin
                        state_d = ST_CLR_ALL;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
            end

            ST_SEARCH: begin
                if (!match_found_q && cur_active && cur_note == cmd_q.note) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx_q;
                end
                if (!free_found_q && !cur_active) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                // Strict compare keeps the lowest index among equally old slots
                if (cur_active && cur_age > old_age_q) begin
                    old_age_d = cur_age;
                    old_idx_d = scan_idx_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    scan_idx_d = '0;
                    state_d    = (!cmd_q.start && !match_found_d) ? ST_IDLE : ST_WRITE;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end

            ST_WRITE: begin
                wr_d = 1'b1;
                if (cmd_q.start) begin
                    if (match_found_q) begin
                        wr_idx = match_idx_q;
                    end else if (free_found_q) begin
                        wr_idx = free_idx_q;
                    end else begin
                        wr_idx  = old_idx_q;
                        steal_d = 1'b1;
                    end
                    data_d  = CMD_W'(cmd_q);
                    age_inc = 1'b1;
                end else begin
                    wr_idx = match_idx_q;
                    data_d = '0;
                end
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (wr_idx == IDX_W'(i)) begin
                        slot_set[i] = cmd_q.start;
                        slot_clr[i] = !cmd_q.start;
                    end
                end
                idx_d   = wr_idx;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INIT_CLR;
            cmd_q         <= '0;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            o_cmd_ready   <= 1'b0;
            o_voice_wr    <= 1'b0;
            o_steal       <= 1'b0;
            o_voice_idx   <= '0;
            o_voice_data  <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            scan_idx_q    <= scan_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            o_cmd_ready   <= (state_d == ST_IDLE);
            o_voice_wr    <= wr_d;
            o_steal       <= steal_d;
            o_voice_idx   <= idx_d;
            o_voice_data  <= data_d;
        end
    end

endmodule
